// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard producing stall, flush and bypass-select controls for ID.
// Each in-flight write counts down until its result reaches the bypass network.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 8,
    parameter int LW      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_regwrite,
    input  logic [AW-1:0]   id_rd,
    input  logic [LW-1:0]   id_lat,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    output logic            stall,
    output logic            pc_write,
    output logic            if2id_write,
    output logic            if2id_flush,
    output logic            id2ex_flush,
    output logic            fwd_rs,
    output logic            fwd_rt,
    output logic [NREG-1:0] pending
);

    logic [NREG-1:0] pend;
    logic [LW-1:0]   cnt [NREG];

    logic [LW-1:0] lat_clamped;
    logic [LW-1:0] eff_lat;

    logic          rs_pend, rt_pend, rd_pend;
    logic [LW-1:0] rs_cnt, rt_cnt, rd_cnt;

    logic rs_hazard, rt_hazard, waw_hazard;
    logic raw_stall;
    logic issue;

    assign lat_clamped = (id_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : id_lat;
    assign eff_lat     = (lat_clamped == '0) ? LW'(1) : lat_clamped;

    // Lookups only match r >= 1, so register 0 never reads as pending and
    // addresses beyond NREG-1 simply miss.
    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        rd_pend = 1'b0;
        rs_cnt  = '0;
        rt_cnt  = '0;
        rd_cnt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (id_rs == AW'(r)) begin
                rs_pend = pend[r];
                rs_cnt  = cnt[r];
            end
            if (id_rt == AW'(r)) begin
                rt_pend = pend[r];
                rt_cnt  = cnt[r];
            end
            if (id_rd == AW'(r)) begin
                rd_pend = pend[r];
                rd_cnt  = cnt[r];
            end
        end
    end

    assign rs_hazard  = id_use_rs & rs_pend & (rs_cnt != '0);
    assign rt_hazard  = id_use_rt & rt_pend & (rt_cnt != '0);
    assign fwd_rs     = id_use_rs & rs_pend & (rs_cnt == '0);
    assign fwd_rt     = id_use_rt & rt_pend & (rt_cnt == '0);
    assign waw_hazard = id_regwrite & rd_pend & (rd_cnt >= eff_lat);

    assign raw_stall = id_valid & (rs_hazard | rt_hazard | waw_hazard);
    assign issue     = id_valid & ~branch_taken & ~raw_stall;

    // A taken branch squashes ID outright, so it outranks the stall.
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        if2id_write = 1'b1;
        if2id_flush = 1'b0;
        id2ex_flush = 1'b0;
        if (branch_taken) begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
        end else if (raw_stall) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if2id_write = 1'b0;
            id2ex_flush = 1'b1;
        end else if (jump) begin
            if2id_flush = 1'b1;
        end
    end

    // Issue beats retire on the same register; retire beats the countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            pend[0] <= 1'b0;
            cnt[0]  <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && id_regwrite && (id_rd == AW'(r))) begin
                    pend[r] <= 1'b1;
                    cnt[r]  <= eff_lat - LW'(1);
                end else if (wb_en && (wb_rd == AW'(r)) && pend[r]) begin
                    pend[r] <= 1'b0;
                    cnt[r]  <= '0;
                end else if (pend[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - LW'(1);
                end
            end
        end
    end

    assign pending = pend;

endmodule
